// File: rtl/gfx256_wbm_reader.sv
// Read-side Wishbone master with round-robin arbitration for the 256-bit GFX memory port.
// Optional one-line read cache enabled by defining GFX256_WBM_READ_CACHE_EN.
module gfx256_wbm_reader #(
  parameter int NREQ = 3,
  parameter int MDW  = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*32-1:0]       addr_i,
  input  logic [NREQ*(MDW/8)-1:0]  sel_i,
  output logic [NREQ-1:0]          ack_o,
  output logic [MDW-1:0]           data_o,
  output logic                     err_o,
  output logic                     wbm_busy_o,
  input  logic                     invalidate_i,
  output logic                     wbm_cyc_o,
  output logic                     wbm_stb_o,
  output logic                     wbm_we_o,
  output logic [31:0]              wbm_adr_o,
  output logic [MDW/8-1:0]         wbm_sel_o,
  input  logic [MDW-1:0]           wbm_dat_i,
  input  logic                     wbm_ack_i,
  input  logic                     wbm_err_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = MDW / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]      r_state;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_win;
  logic [NREQ-1:0] r_ack;
  logic [MDW-1:0]  r_data;
  logic            r_err;
  logic            r_cyc;
  logic [31:0]     r_adr;
  logic [SW-1:0]   r_sel;

  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_cand;
  logic [31:0]     w_waddr;
  logic [SW-1:0]   w_wsel;
  logic            w_hit;
  logic            w_unused;

  // Round-robin: first requester found scanning upward from last+1.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IW'((int'(r_last) + k) % NREQ);
      if (!w_found && req_i[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_waddr = addr_i[32*int'(w_win) +: 32];
  assign w_wsel  = sel_i[SW*int'(w_win) +: SW];

`ifdef GFX256_WBM_READ_CACHE_EN
  logic           r_cv;
  logic [26:0]    r_ctag;
  logic [MDW-1:0] r_cline;

  assign w_hit = r_cv && (r_ctag == w_waddr[31:5]);
`else
  assign w_hit = 1'b0;
`endif

  assign w_unused = ^{invalidate_i, w_waddr[4:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_last  <= IW'(NREQ - 1);
      r_win   <= '0;
      r_ack   <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_cyc   <= 1'b0;
      r_adr   <= '0;
      r_sel   <= '0;
`ifdef GFX256_WBM_READ_CACHE_EN
      r_cv    <= 1'b0;
`endif
    end else begin
      r_ack <= '0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_win  <= w_win;
            r_last <= w_win;
            r_adr  <= {w_waddr[31:5], 5'b0};
            r_sel  <= w_wsel;
            if (w_hit) begin
`ifdef GFX256_WBM_READ_CACHE_EN
              r_data <= r_cline;
`endif
              r_ack   <= NREQ'(1) << w_win;
              r_state <= S_ACK;
            end else begin
              r_cyc   <= 1'b1;
              r_state <= S_BUS;
            end
          end
        end
        S_BUS: begin
          // Error has priority over a simultaneous ack and never fills the cache.
          if (wbm_err_i) begin
            r_cyc   <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b1;
            r_ack   <= NREQ'(1) << r_win;
            r_state <= S_ACK;
          end else if (wbm_ack_i) begin
            r_cyc   <= 1'b0;
            r_data  <= wbm_dat_i;
            r_ack   <= NREQ'(1) << r_win;
            r_state <= S_ACK;
`ifdef GFX256_WBM_READ_CACHE_EN
            r_cv    <= 1'b1;
            r_ctag  <= r_adr[31:5];
            r_cline <= wbm_dat_i;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef GFX256_WBM_READ_CACHE_EN
      if (invalidate_i) r_cv <= 1'b0;
`endif
    end
  end

  assign ack_o      = r_ack;
  assign data_o     = r_data;
  assign err_o      = r_err;
  assign wbm_busy_o = (r_state != S_IDLE);
  assign wbm_cyc_o  = r_cyc;
  assign wbm_stb_o  = r_cyc;
  assign wbm_we_o   = 1'b0;
  assign wbm_adr_o  = r_adr;
  assign wbm_sel_o  = r_sel;

endmodule

// File: tb/tb_gfx256_wbm_reader.sv
// Scoreboard bench for gfx256_wbm_reader: directed reads against a bench-side Wishbone slave.
// Expected cache behaviour follows GFX256_WBM_READ_CACHE_EN.
module tb_gfx256_wbm_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req;
  logic [95:0]  addr;
  logic [95:0]  sel;
  logic [2:0]   ack;
  logic [255:0] data;
  logic         err;
  logic         busy;
  logic         inv;
  logic         cyc;
  logic         stb;
  logic         we;
  logic [31:0]  adr;
  logic [31:0]  wsel;
  logic [255:0] dat_i = '0;
  logic         wack = 1'b0;
  logic         werr = 1'b0;

  always #5 clk = ~clk;

  gfx256_wbm_reader #(.NREQ(3), .MDW(256)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .sel_i(sel),
    .ack_o(ack), .data_o(data), .err_o(err), .wbm_busy_o(busy),
    .invalidate_i(inv), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
    .wbm_adr_o(adr), .wbm_sel_o(wsel), .wbm_dat_i(dat_i),
    .wbm_ack_i(wack), .wbm_err_i(werr)
  );

  typedef struct {
    logic [2:0]   ack;
    logic [255:0] data;
    logic         err;
    int           at;
  } exp_t;

  typedef struct {
    string        name;
    logic [255:0] act;
    logic [255:0] exp;
  } chk_t;

  exp_t        expq[$];
  chk_t        chkq[$];
  logic [31:0] badr_q[$];
  logic [31:0] bsel_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_n = 0;
  int          nbus = 0;
  int          slv_wait = 0;
  logic        slv_err = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // Bench slave: acks (or errors) after slv_wait wait states; line = address replicated.
  initial begin : slave
    int   wcnt;
    logic prev_cyc;
    wcnt = 0;
    prev_cyc = 1'b0;
    forever begin
      @(negedge clk);
      if (cyc && !prev_cyc) begin
        nbus++;
        badr_q.push_back(adr);
        bsel_q.push_back(wsel);
      end
      prev_cyc = cyc;
      if (cyc && stb) begin
        if (!wack && !werr) begin
          if (wcnt >= slv_wait) begin
            wack  = !slv_err;
            werr  = slv_err;
            dat_i = slv_err ? {8{32'hDEAD_BEEF}} : {8{adr}};
          end else begin
            wcnt++;
          end
        end
      end else begin
        wack = 1'b0;
        werr = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic cmp(input string n, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Monitor: drains queued direct checks and scores every ack pulse against the queue.
  initial begin : monitor
    chk_t c;
    exp_t e;
    forever begin
      @(negedge clk);
      while (chkq.size() > 0) begin
        c = chkq.pop_front();
        cmp(c.name, c.act, c.exp);
      end
      if (ack !== 3'b000) begin
        if (expq.size() == 0) begin
          cmp("unexpected_ack", {253'b0, ack}, 256'b0);
        end else begin
          e = expq.pop_front();
          cmp("ack_idx", {253'b0, ack}, {253'b0, e.ack});
          cmp("ack_data", data, e.data);
          cmp("ack_err", {255'b0, err}, {255'b0, e.err});
          if (e.at >= 0) cmp("ack_time", 256'(cyc_n), 256'(e.at));
        end
      end else if (err === 1'b1) begin
        cmp("err_without_ack", {255'b0, err}, 256'b0);
      end
    end
  end

  task automatic push_chk(input string n, input logic [255:0] a, input logic [255:0] e);
    chk_t c;
    c.name = n;
    c.act  = a;
    c.exp  = e;
    chkq.push_back(c);
  endtask

  task automatic wait_ack(input int idx);
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (ack[idx]) return;
    end
    push_chk("ack_timeout", {253'b0, ack}, 256'(3'b001 << idx));
  endtask

  // lat: edges from the grant edge to the edge that raises ack (miss = waits+1, hit = 0).
  task automatic do_read(input int idx, input logic [31:0] a, input logic [31:0] s,
                         input int w, input logic e, input logic [255:0] expd, input int lat);
    exp_t x;
    logic [2:0] oh;
    @(negedge clk);
    slv_wait = w;
    slv_err  = e;
    addr[idx*32 +: 32] = a;
    sel[idx*32 +: 32]  = s;
    oh     = 3'b001 << idx;
    x.ack  = oh;
    x.data = expd;
    x.err  = e;
    x.at   = cyc_n + 1 + lat;
    expq.push_back(x);
    req[idx] = 1'b1;
    wait_ack(idx);
    req[idx] = 1'b0;
  endtask

  initial begin : stim
    logic [31:0] ea[3];
    logic [31:0] es[3];
    exp_t x;
    int nb0;
    int nb1;
    ea = '{32'h0000_0040, 32'h0000_0080, 32'h0000_00C0};
    es = '{32'hFFFF_FFFF, 32'h0000_00F0, 32'h0000_000F};
    rst = 1'b1; req = '0; addr = '0; sel = '0; inv = 1'b0;
    repeat (2) @(negedge clk);
    push_chk("rst_ctrl", {248'b0, cyc, stb, we, busy, err, ack}, 256'b0);
    push_chk("rst_adr", {224'b0, adr}, 256'b0);
    push_chk("rst_sel", {224'b0, wsel}, 256'b0);
    push_chk("rst_data", data, 256'b0);

    // Contention straight out of reset: grants 0, 1, 2.
    rst = 1'b0;
    slv_wait = 0; slv_err = 1'b0;
    addr = {32'h0000_00C4, 32'h0000_0084, 32'h0000_0044};
    sel  = {32'h0000_000F, 32'h0000_00F0, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      x.ack = 3'b001 << i; x.data = {8{ea[i]}}; x.err = 1'b0; x.at = -1;
      expq.push_back(x);
    end
    req = 3'b111;
    for (int t = 0; t < 60 && req != 3'b000; t++) begin
      @(negedge clk);
      req = req & ~ack;
    end
    push_chk("contention_done", {253'b0, req}, 256'b0);
    push_chk("contention_nbus", 256'(nbus), 256'(3));
    for (int i = 0; i < 3; i++) begin
      push_chk("contention_adr", {224'b0, badr_q[i]}, {224'b0, ea[i]});
      push_chk("contention_sel", {224'b0, bsel_q[i]}, {224'b0, es[i]});
    end

    do_read(1, 32'h0000_1234, 32'h00FF_FF00, 2, 1'b0, {8{32'h0000_1220}}, 3);
    push_chk("single_adr", {224'b0, badr_q[$]}, {224'b0, 32'h0000_1220});
    push_chk("single_sel", {224'b0, bsel_q[$]}, {224'b0, 32'h00FF_FF00});

    do_read(2, 32'h0000_0100, 32'hFFFF_FFFF, 1, 1'b1, 256'b0, 2);
    @(negedge clk);
    push_chk("err_back_idle", {255'b0, busy}, 256'b0);
    push_chk("err_adr", {224'b0, badr_q[$]}, {224'b0, 32'h0000_0100});

    // Reset while the slave is still holding off the ack.
    @(negedge clk);
    slv_wait = 30; slv_err = 1'b0;
    addr[31:0] = 32'h0000_0500;
    req[0] = 1'b1;
    repeat (3) @(negedge clk);
    push_chk("bus_busy", {253'b0, busy, cyc, stb}, {253'b0, 3'b111});
    rst = 1'b1;
    @(negedge clk);
    push_chk("rst_mid_bus", {250'b0, cyc, stb, busy, ack}, 256'b0);
    rst = 1'b0; req[0] = 1'b0;
    repeat (3) @(negedge clk);
    push_chk("post_rst_idle", {254'b0, cyc, busy}, 256'b0);

    nb0 = nbus;
    do_read(0, 32'h0000_2000, 32'hFFFF_FFFF, 1, 1'b0, {8{32'h0000_2000}}, 2);
`ifdef GFX256_WBM_READ_CACHE_EN
    do_read(0, 32'h0000_2010, 32'hFFFF_FFFF, 1, 1'b0, {8{32'h0000_2000}}, 0);
    push_chk("hit_nbus", 256'(nbus - nb0), 256'(1));
`else
    do_read(0, 32'h0000_2010, 32'hFFFF_FFFF, 1, 1'b0, {8{32'h0000_2000}}, 2);
    push_chk("nocache_nbus", 256'(nbus - nb0), 256'(2));
`endif
    @(negedge clk); inv = 1'b1;
    @(negedge clk); inv = 1'b0;
    do_read(0, 32'h0000_2000, 32'hFFFF_FFFF, 1, 1'b0, {8{32'h0000_2000}}, 2);
`ifdef GFX256_WBM_READ_CACHE_EN
    push_chk("after_inv_nbus", 256'(nbus - nb0), 256'(2));
`else
    push_chk("after_inv_nbus", 256'(nbus - nb0), 256'(3));
`endif

    // Invalidate sampled on the same edge as the fill: next read must miss.
    nb1 = nbus;
    @(negedge clk);
    slv_wait = 1; slv_err = 1'b0;
    addr[31:0] = 32'h0000_3000;
    x.ack = 3'b001; x.data = {8{32'h0000_3000}}; x.err = 1'b0; x.at = cyc_n + 3;
    expq.push_back(x);
    req[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    inv = 1'b1;
    wait_ack(0);
    inv = 1'b0; req[0] = 1'b0;
    do_read(0, 32'h0000_3000, 32'hFFFF_FFFF, 1, 1'b0, {8{32'h0000_3000}}, 2);
    push_chk("inv_vs_fill_nbus", 256'(nbus - nb1), 256'(2));

    repeat (3) @(negedge clk);
    push_chk("exp_q_empty", 256'(expq.size()), 256'b0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
